ext_dump_uart: RTL

Debug read-out engine that drives the processor datapath's external inspection ports: the data-memory port (`extmemaddress` / `extmemdata`) and the register-file port (`swval` / `rdval`). On a start request it sweeps the selected space and returns every 32-bit word to a host over an 8N1 UART transmit line. It sits beside the datapath at board top level and replaces switch-driven manual inspection on the FPGA.

---
 rtl/ext_dump_uart.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/ext_dump_uart.sv
`default_nettype none
// ============================================================================
//  Module   : ext_dump_uart
//  Purpose  : Debug read-out engine. On a start request it sweeps either the
//             data memory (extmemaddress/extmemdata) or the register file
//             (swval/rdval) and streams every 32-bit word, MSB byte first,
//             over an 8N1 UART transmit line, preceded by one sync byte
//             (0xA5 = memory dump, 0x5A = register dump).
//  Ports    : clk, reset (async, active high)
//             start, mode       - request and dump-space select
//             extmemaddress/extmemdata - data-memory inspection port
//             swval/rdval       - register-file inspection port
//             tx                - UART serial output (idle high)
//             busy, done        - dump in progress / completion pulse
//  Revision : 1.0 - initial release
// ============================================================================
module ext_dump_uart #(
  parameter int CLKS_PER_BIT = 434,
  parameter int MEM_WORDS    = 512,
  parameter int NUM_REGS     = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        mode,
  output logic [8:0]  extmemaddress,
  input  logic [31:0] extmemdata,
  output logic [4:0]  swval,
  input  logic [31:0] rdval,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  localparam int c_cw = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [c_cw-1:0] c_clk_max  = c_cw'(CLKS_PER_BIT - 1);
  localparam logic [8:0]      c_last_mem = 9'(MEM_WORDS - 1);
  localparam logic [8:0]      c_last_reg = 9'(NUM_REGS - 1);

  localparam logic [2:0] c_idle = 3'd0;
  localparam logic [2:0] c_sync = 3'd1;
  localparam logic [2:0] c_addr = 3'd2;
  localparam logic [2:0] c_capt = 3'd3;
  localparam logic [2:0] c_send = 3'd4;
  localparam logic [2:0] c_fin  = 3'd5;

  logic [2:0]      r_state;
  logic            r_mode;
  logic [8:0]      r_idx;
  logic [31:0]     r_word;
  logic [1:0]      r_byte_cnt;
  logic [8:0]      r_frame;     // remaining data bits followed by the stop bit
  logic [3:0]      r_bit_cnt;   // 0 = start bit, 1..8 = data, 9 = stop
  logic [c_cw-1:0] r_clk_cnt;
  logic            r_tx;
  logic            r_busy;
  logic            r_done;
  logic [8:0]      r_memaddr;
  logic [4:0]      r_swval;

  logic            w_bit_end;
  logic            w_frame_end;
  logic            w_last_idx;
  logic            w_load;
  logic [7:0]      w_load_byte;
  logic [31:0]     w_rd_data;

  assign w_bit_end   = (r_clk_cnt == c_clk_max);
  assign w_frame_end = w_bit_end && (r_bit_cnt == 4'd9);
  assign w_last_idx  = (r_idx == (r_mode ? c_last_reg : c_last_mem));
  assign w_rd_data   = r_mode ? rdval : extmemdata;

  // A new frame starts with its start bit on the same edge the previous
  // stop bit ends, so consecutive bytes of one word have no idle gap.
  assign w_load = ((r_state == c_idle) && start) ||
                  (r_state == c_capt) ||
                  ((r_state == c_send) && w_frame_end && (r_byte_cnt != 2'd3));

  always_comb begin
    w_load_byte = r_word[31:24];
    if (r_state == c_idle) begin
      w_load_byte = mode ? 8'h5A : 8'hA5;
    end else if (r_state == c_capt) begin
      w_load_byte = w_rd_data[31:24];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= c_idle;
      r_mode     <= 1'b0;
      r_idx      <= 9'd0;
      r_word     <= 32'd0;
      r_byte_cnt <= 2'd0;
      r_frame    <= 9'h1FF;
      r_bit_cnt  <= 4'd0;
      r_clk_cnt  <= '0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_memaddr  <= 9'd0;
      r_swval    <= 5'd0;
    end else begin
      r_done <= 1'b0;

      // Bit timing runs only while a frame is on the line.
      if ((r_state == c_sync) || (r_state == c_send)) begin
        if (w_bit_end) begin
          r_clk_cnt <= '0;
          if (!w_frame_end) begin
            r_bit_cnt <= r_bit_cnt + 4'd1;
            r_tx      <= r_frame[0];
            r_frame   <= {1'b1, r_frame[8:1]};
          end
        end else begin
          r_clk_cnt <= r_clk_cnt + c_cw'(1);
        end
      end

      case (r_state)
        c_idle: begin
          if (start) begin
            r_mode    <= mode;
            r_idx     <= 9'd0;
            r_busy    <= 1'b1;
            r_memaddr <= 9'd0;
            r_swval   <= 5'd0;
            r_state   <= c_sync;
          end
        end
        c_sync: begin
          if (w_frame_end) begin
            r_state <= c_addr;
          end
        end
        c_addr: begin
          // The unused index output is held at zero.
          if (r_mode) begin
            r_swval   <= r_idx[4:0];
            r_memaddr <= 9'd0;
          end else begin
            r_memaddr <= r_idx;
            r_swval   <= 5'd0;
          end
          r_state <= c_capt;
        end
        c_capt: begin
          // Byte 0 goes straight into the frame; keep the rest pre-shifted.
          r_word     <= {w_rd_data[23:0], 8'h00};
          r_byte_cnt <= 2'd0;
          r_state    <= c_send;
        end
        c_send: begin
          if (w_frame_end) begin
            if (r_byte_cnt == 2'd3) begin
              if (w_last_idx) begin
                r_done  <= 1'b1;
                r_state <= c_fin;
              end else begin
                r_idx   <= r_idx + 9'd1;
                r_state <= c_addr;
              end
            end else begin
              r_byte_cnt <= r_byte_cnt + 2'd1;
              r_word     <= {r_word[23:0], 8'h00};
            end
          end
        end
        c_fin: begin
          r_busy  <= 1'b0;
          r_state <= c_idle;
        end
        default: begin
          r_state <= c_idle;
        end
      endcase

      if (w_load) begin
        r_tx      <= 1'b0;
        r_frame   <= {1'b1, w_load_byte};
        r_bit_cnt <= 4'd0;
        r_clk_cnt <= '0;
      end
    end
  end

  assign extmemaddress = r_memaddr;
  assign swval         = r_swval;
  assign tx            = r_tx;
  assign busy          = r_busy;
  assign done          = r_done;

endmodule
`default_nettype wire
